exception_ctrl: RTL

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

---
 rtl/exception_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/exception_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exception_ctrl
// Description : MEM-stage exception detector and pipeline redirect controller.
//               Synchronizes the external interrupt lines, prioritizes the
//               interrupt against the instruction exception flags, registers
//               the exception record for CP0 and drives a multi-cycle
//               flush/redirect toward the exception vector or the EPC.
//
// Ports
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   mem_valid         : MEM-stage instruction valid
//   mem_pc            : MEM-stage instruction address
//   mem_in_delayslot  : MEM-stage instruction sits in a branch delay slot
//   mem_excflags      : [0] fetch AdEL [1] RI [2] SYSCALL [3] BREAK
//                       [4] OV [5] load AdEL [6] store AdES [7] ERET
//   mem_data_addr     : MEM-stage load/store effective address
//   cp0_status/cause/epc : current CP0 register values
//   ext_int           : raw asynchronous interrupt lines
//   int_sync_o        : synchronized interrupt lines for CP0
//   excepttype_o      : one-cycle exception code (0 = none)
//   exc_pc_o          : faulting instruction address
//   exc_delayslot_o   : faulting instruction was in a delay slot
//   bad_addr_o        : bad virtual address
//   flush_o           : pipeline flush request
//   newpc_o           : redirect target, valid while flush_o = 1
//
// Revision    : 1.0 - initial release
// ============================================================================
module exception_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    // Legal range 1..15; the flush counter is 4 bits wide.
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_in_delayslot,
    input  logic [7:0]  mem_excflags,
    input  logic [31:0] mem_data_addr,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    input  logic [5:0]  ext_int,
    output logic [5:0]  int_sync_o,
    output logic [31:0] excepttype_o,
    output logic [31:0] exc_pc_o,
    output logic        exc_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic [31:0] newpc_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [3:0]  c_flush_last = 4'(FLUSH_CYCLES - 1);

    localparam logic [31:0] c_code_none  = 32'h0;
    localparam logic [31:0] c_code_int   = 32'h1;
    localparam logic [31:0] c_code_adel  = 32'h4;
    localparam logic [31:0] c_code_ades  = 32'h5;
    localparam logic [31:0] c_code_sys   = 32'h8;
    localparam logic [31:0] c_code_bp    = 32'h9;
    localparam logic [31:0] c_code_ri    = 32'ha;
    localparam logic [31:0] c_code_ov    = 32'hc;
    localparam logic [31:0] c_code_eret  = 32'he;

    // Where the bad virtual address comes from for the winning exception.
    localparam logic [1:0]  c_bad_hold   = 2'd0;
    localparam logic [1:0]  c_bad_pc     = 2'd1;
    localparam logic [1:0]  c_bad_data   = 2'd2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t      r_state;
    logic [3:0]  r_flush_cnt;
    logic [5:0]  r_int_meta;
    logic [5:0]  r_int_sync;
    logic [31:0] r_excepttype;
    logic [31:0] r_exc_pc;
    logic        r_exc_delayslot;
    logic [31:0] r_bad_addr;
    logic        r_flush;
    logic [31:0] r_newpc;

    // ------------------------------------------------------------------------
    // Combinational detection
    // ------------------------------------------------------------------------
    logic        w_int_pending;
    logic [31:0] w_code;
    logic [1:0]  w_bad_sel;
    logic [31:0] w_bad_next;
    logic [31:0] w_newpc_next;

    // IE set, EXL clear, and at least one enabled pending interrupt.
    assign w_int_pending = cp0_status[0] & ~cp0_status[1]
                         & (|(cp0_cause[15:8] & cp0_status[15:8]));

    // Priority chain; an instruction in MEM is only examined while idle, so
    // anything arriving during a flush is dropped rather than queued.
    always_comb begin
        w_code    = c_code_none;
        w_bad_sel = c_bad_hold;
        if (mem_valid && (r_state == ST_IDLE)) begin
            if (w_int_pending) begin
                w_code = c_code_int;
            end else if (mem_excflags[0]) begin
                w_code    = c_code_adel;
                w_bad_sel = c_bad_pc;
            end else if (mem_excflags[1]) begin
                w_code = c_code_ri;
            end else if (mem_excflags[4]) begin
                w_code = c_code_ov;
            end else if (mem_excflags[2]) begin
                w_code = c_code_sys;
            end else if (mem_excflags[3]) begin
                w_code = c_code_bp;
            end else if (mem_excflags[5]) begin
                w_code    = c_code_adel;
                w_bad_sel = c_bad_data;
            end else if (mem_excflags[6]) begin
                w_code    = c_code_ades;
                w_bad_sel = c_bad_data;
            end else if (mem_excflags[7]) begin
                w_code = c_code_eret;
            end
        end
    end

    always_comb begin
        w_bad_next = r_bad_addr;
        case (w_bad_sel)
            c_bad_pc:   w_bad_next = mem_pc;
            c_bad_data: w_bad_next = mem_data_addr;
            default:    w_bad_next = r_bad_addr;
        endcase
    end

    assign w_newpc_next = (w_code == c_code_eret) ? cp0_epc : EXC_VECTOR;

    // ------------------------------------------------------------------------
    // Sequential: synchronizer, exception record and flush FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_flush_cnt     <= 4'd0;
            r_int_meta      <= 6'd0;
            r_int_sync      <= 6'd0;
            r_excepttype    <= 32'h0;
            r_exc_pc        <= 32'h0;
            r_exc_delayslot <= 1'b0;
            r_bad_addr      <= 32'h0;
            r_flush         <= 1'b0;
            r_newpc         <= 32'h0;
        end else begin
            r_int_meta <= ext_int;
            r_int_sync <= r_int_meta;

            // w_code is forced to zero outside IDLE, so the code register is
            // nonzero for exactly the detection cycle.
            r_excepttype <= w_code;

            case (r_state)
                ST_IDLE: begin
                    if (w_code != c_code_none) begin
                        r_state         <= ST_FLUSH;
                        r_flush_cnt     <= 4'd0;
                        r_flush         <= 1'b1;
                        r_newpc         <= w_newpc_next;
                        r_exc_pc        <= mem_pc;
                        r_exc_delayslot <= mem_in_delayslot;
                        r_bad_addr      <= w_bad_next;
                    end
                end
                ST_FLUSH: begin
                    if (r_flush_cnt == c_flush_last) begin
                        r_state     <= ST_IDLE;
                        r_flush_cnt <= 4'd0;
                        r_flush     <= 1'b0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_flush_cnt <= 4'd0;
                    r_flush     <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign int_sync_o      = r_int_sync;
    assign excepttype_o    = r_excepttype;
    assign exc_pc_o        = r_exc_pc;
    assign exc_delayslot_o = r_exc_delayslot;
    assign bad_addr_o      = r_bad_addr;
    assign flush_o         = r_flush;
    assign newpc_o         = r_newpc;

    // CP0 fields this block does not interpret.
    logic w_unused;
    assign w_unused = ^{cp0_status[31:16], cp0_status[7:2],
                        cp0_cause[31:16], cp0_cause[7:0]};

endmodule
`default_nettype wire
